// File: rtl/barcode_entry_sequencer_pkg.sv
// Shared definitions for the barcode entry sequencer: state codes, key codes
// and the default barcode length.
package barcode_entry_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_FULL    = 3'd2,
    ST_LOOKUP  = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  localparam int NUM_DIGITS_DEFAULT = 4;
  localparam int COUNT_W            = 3;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/barcode_entry_sequencer_lookup_timeout_counter.sv
// Saturating cycle counter for the product lookup; expired_o flags the cycle in
// which the count reaches LOOKUP_TIMEOUT, so the caller can act on that edge.
module lookup_timeout_counter #(
  parameter int LOOKUP_TIMEOUT = 1000
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(LOOKUP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LOOKUP_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign expired_o = enable_i && !clear_i && (cnt_d == LIMIT);

endmodule

// File: rtl/barcode_entry_sequencer.sv
// Keypad-to-barcode entry FSM: shifts digits out one cycle after each key strobe,
// then runs a request/ack product lookup with timeout. All outputs registered.
module barcode_entry_sequencer
  import barcode_entry_sequencer_pkg::*;
#(
  parameter int NUM_DIGITS     = NUM_DIGITS_DEFAULT,
  parameter int LOOKUP_TIMEOUT = 1000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               key_valid_i,
  input  logic [3:0]         key_code_i,
  input  logic               lookup_ack_i,
  input  logic               lookup_found_i,
  output logic               sr_enable_o,
  output logic [3:0]         sr_digit_o,
  output logic               sr_reset_n_o,
  output logic               lookup_req_o,
  output logic               entry_done_o,
  output logic               entry_error_o,
  output logic [COUNT_W-1:0] digit_count_o,
  output logic [2:0]         state_o
);

  state_e             state_q;
  logic [COUNT_W-1:0] count_q;
  logic               sr_enable_q;
  logic [3:0]         sr_digit_q;
  logic               sr_reset_n_q;
  logic               lookup_req_q;
  logic               entry_done_q;
  logic               entry_error_q;

  logic key_digit, key_enter, key_clear;
  logic enter_lookup, last_digit, timeout_expired;

  assign key_digit    = key_valid_i && is_digit(key_code_i);
  assign key_enter    = key_valid_i && (key_code_i == KEY_ENTER);
  assign key_clear    = key_valid_i && (key_code_i == KEY_CLEAR);
  assign enter_lookup = (state_q == ST_FULL) && key_enter;
  assign last_digit   = (count_q == COUNT_W'(NUM_DIGITS - 1));

  lookup_timeout_counter #(
    .LOOKUP_TIMEOUT(LOOKUP_TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .clear_i  (reset_i || enter_lookup),
    .enable_i (state_q == ST_LOOKUP),
    .expired_o(timeout_expired)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      sr_enable_q   <= 1'b0;
      sr_digit_q    <= '0;
      sr_reset_n_q  <= 1'b0;
      lookup_req_q  <= 1'b0;
      entry_done_q  <= 1'b0;
      entry_error_q <= 1'b0;
    end else begin
      sr_enable_q   <= 1'b0;
      sr_reset_n_q  <= 1'b1;
      entry_done_q  <= 1'b0;
      entry_error_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_COLLECT: begin
          if (key_clear) begin
            sr_reset_n_q <= 1'b0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
          end else if (key_enter) begin
            entry_error_q <= 1'b1;
          end else if (key_digit) begin
            sr_enable_q <= 1'b1;
            sr_digit_q  <= key_code_i;
            count_q     <= count_q + COUNT_W'(1);
            state_q     <= last_digit ? ST_FULL : ST_COLLECT;
          end
        end
        ST_FULL: begin
          if (key_clear) begin
            sr_reset_n_q <= 1'b0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
          end else if (key_enter) begin
            lookup_req_q <= 1'b1;
            state_q      <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          // A late ack on the expiry cycle still counts as an answer.
          if (lookup_ack_i) begin
            lookup_req_q <= 1'b0;
            if (lookup_found_i) begin
              entry_done_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              entry_error_q <= 1'b1;
              state_q       <= ST_ERROR;
            end
          end else if (timeout_expired) begin
            lookup_req_q  <= 1'b0;
            entry_error_q <= 1'b1;
            state_q       <= ST_ERROR;
          end
        end
        ST_DONE: begin
          sr_reset_n_q <= 1'b0;
          count_q      <= '0;
          state_q      <= ST_IDLE;
        end
        ST_ERROR: begin
          if (key_clear) begin
            sr_reset_n_q <= 1'b0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          lookup_req_q <= 1'b0;
          count_q      <= '0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign sr_enable_o   = sr_enable_q;
  assign sr_digit_o    = sr_digit_q;
  assign sr_reset_n_o  = sr_reset_n_q;
  assign lookup_req_o  = lookup_req_q;
  assign entry_done_o  = entry_done_q;
  assign entry_error_o = entry_error_q;
  assign digit_count_o = count_q;
  assign state_o       = state_q;

endmodule
